// File: rtl/sys_ctrl_gen2.sv
// sys_ctrl_gen2 : REF_CLK-domain system controller.
// Parses UART command frames (RF write/read, ALU with/without operands,
// burst write) and drives the register file, the ALU, its clock gate and the
// TX FIFO. Includes an inter-byte timeout and one-cycle CMD_ERR reporting.
//
// Build option: define SYS_CTRL_ERR_RESP_EN to also queue an all-ones token
// into the TX FIFO for every CMD_ERR event. Without it, errors only pulse
// CMD_ERR.
//
// Ports:
//   CLK, RST (async, active-low)
//   RX_D/RX_D_VLD            : synchronised RX byte stream
//   RF_RD_DATA/RF_RD_VLD     : register file read return
//   ALU_OUT/ALU_OUT_VLD      : ALU result return
//   FIFO_FULL                : TX FIFO back-pressure
//   RF_WR_EN/RF_RD_EN/RF_ADDR/RF_WR_DATA : register file access
//   ALU_EN/ALU_FUN/CLK_GATE_EN           : ALU control
//   FIFO_WR_DATA/FIFO_WR_INC             : TX FIFO push
//   CMD_ERR                  : one-cycle error pulse
//   BUSY                     : high whenever not IDLE
module sys_ctrl_gen2 #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_W     = 4,
  parameter int ALU_OUT_BYTES = 2,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [BUS_WIDTH-1:0]               RX_D,
  input  logic                               RX_D_VLD,
  input  logic [BUS_WIDTH-1:0]               RF_RD_DATA,
  input  logic                               RF_RD_VLD,
  input  logic [ALU_OUT_BYTES*BUS_WIDTH-1:0] ALU_OUT,
  input  logic                               ALU_OUT_VLD,
  input  logic                               FIFO_FULL,
  output logic                               RF_WR_EN,
  output logic                               RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]              RF_ADDR,
  output logic [BUS_WIDTH-1:0]               RF_WR_DATA,
  output logic                               ALU_EN,
  output logic [ALU_FUN_W-1:0]               ALU_FUN,
  output logic                               CLK_GATE_EN,
  output logic [BUS_WIDTH-1:0]               FIFO_WR_DATA,
  output logic                               FIFO_WR_INC,
  output logic                               CMD_ERR,
  output logic                               BUSY
);

  localparam int OUT_W  = ALU_OUT_BYTES * BUS_WIDTH;
  localparam int TXL_W  = $clog2(ALU_OUT_BYTES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC);
  localparam int ERRQ_W = 3;

`ifdef SYS_CTRL_ERR_RESP_EN
  localparam bit ERR_RESP = 1'b1;
`else
  localparam bit ERR_RESP = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_WDATA, GET_CNT, BURST_DATA, RD_WAIT,
    GET_OPA, GET_OPB, GET_FUN, ALU_WAIT, TX_OUT
  } state_t;

  typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_BURST} cmd_t;

  state_t                 state, state_nxt;
  cmd_t                   cmd;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [BUS_WIDTH-1:0]   cnt;
  logic                   alu_start;
  logic [OUT_W-1:0]       tx_buf;
  logic [TXL_W-1:0]       tx_left;
  logic [ERRQ_W-1:0]      err_q, err_q_nxt;
  logic [TMO_W-1:0]       tmo_cnt;

  logic                   timed, tmo_hit, rd_cap, alu_cap, tx_wr, err_evt;
  logic                   wr_en_d, rd_en_d, alu_en_d, gate_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [BUS_WIDTH-1:0]   wdata_d;
  logic [ALU_FUN_W-1:0]   fun_d;
  state_t                 err_target;

  assign timed   = state inside {GET_ADDR, GET_WDATA, GET_CNT, BURST_DATA, RD_WAIT,
                                 GET_OPA, GET_OPB, GET_FUN, ALU_WAIT};
  assign rd_cap  = (state == RD_WAIT) && RF_RD_VLD;
  assign alu_cap = (state == ALU_WAIT) && !alu_start && ALU_OUT_VLD;
  assign tx_wr   = (state == TX_OUT) && !FIFO_FULL;
  // An arriving byte or a returning result beats a same-cycle expiry.
  assign tmo_hit = timed && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) &&
                   !RX_D_VLD && !rd_cap && !alu_cap;
  assign err_target = ERR_RESP ? TX_OUT : IDLE;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    err_evt   = 1'b0;
    case (state)
      IDLE: if (RX_D_VLD) begin
        case (RX_D[7:0])
          8'hAA, 8'hBB, 8'hEE: state_nxt = GET_ADDR;
          8'hCC:               state_nxt = GET_OPA;
          8'hDD:               state_nxt = GET_FUN;
          default: begin err_evt = 1'b1; state_nxt = err_target; end
        endcase
      end
      GET_ADDR: if (RX_D_VLD) begin
        case (cmd)
          CMD_WR:  state_nxt = GET_WDATA;
          CMD_RD:  state_nxt = RD_WAIT;
          default: state_nxt = GET_CNT;
        endcase
      end
      GET_WDATA: if (RX_D_VLD) state_nxt = IDLE;
      GET_CNT: if (RX_D_VLD) begin
        if (RX_D == '0) begin err_evt = 1'b1; state_nxt = err_target; end
        else state_nxt = BURST_DATA;
      end
      BURST_DATA: if (RX_D_VLD && cnt == BUS_WIDTH'(1)) state_nxt = IDLE;
      RD_WAIT: begin
        err_evt = RX_D_VLD;
        if (rd_cap) state_nxt = TX_OUT;
      end
      GET_OPA: if (RX_D_VLD) state_nxt = GET_OPB;
      GET_OPB: if (RX_D_VLD) state_nxt = GET_FUN;
      GET_FUN: if (RX_D_VLD) state_nxt = ALU_WAIT;
      ALU_WAIT: begin
        err_evt = RX_D_VLD;
        if (alu_cap) state_nxt = TX_OUT;
      end
      TX_OUT: err_evt = RX_D_VLD;
      default: state_nxt = IDLE;
    endcase
    if (tmo_hit) begin
      err_evt   = 1'b1;
      state_nxt = err_target;
    end
    // Pending error tokens: one per error event, consumed once data bytes are out.
    err_q_nxt = err_q;
    if (ERR_RESP && err_evt && err_q != '1) err_q_nxt = err_q_nxt + ERRQ_W'(1);
    if (tx_wr && tx_left == '0)              err_q_nxt = err_q_nxt - ERRQ_W'(1);
    if (tx_wr && tx_left <= TXL_W'(1) && err_q_nxt == '0) state_nxt = IDLE;
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    addr_d   = RF_ADDR;
    wdata_d  = RF_WR_DATA;
    fun_d    = ALU_FUN;
    gate_d   = CLK_GATE_EN;
    alu_en_d = (state == ALU_WAIT) && alu_start && !tmo_hit;
    if (RX_D_VLD) begin
      case (state)
        GET_ADDR: if (cmd == CMD_RD) begin
          rd_en_d = 1'b1;
          addr_d  = RX_D[ADDR_WIDTH-1:0];
        end
        GET_WDATA, BURST_DATA: begin
          wr_en_d = 1'b1;
          addr_d  = addr;
          wdata_d = RX_D;
        end
        GET_OPA: begin wr_en_d = 1'b1; addr_d = '0;              wdata_d = RX_D; end
        GET_OPB: begin wr_en_d = 1'b1; addr_d = ADDR_WIDTH'(1); wdata_d = RX_D; end
        GET_FUN: begin gate_d = 1'b1; fun_d = RX_D[ALU_FUN_W-1:0]; end
        default: ;
      endcase
    end
    if (alu_cap || tmo_hit || state == IDLE) gate_d = 1'b0;
  end

  assign FIFO_WR_INC  = tx_wr;
  assign FIFO_WR_DATA = (state != TX_OUT) ? '0 :
                        (tx_left != '0)   ? tx_buf[BUS_WIDTH-1:0] : '1;
  assign BUSY         = (state != IDLE);

  // Registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_DATA  <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      RF_WR_EN    <= wr_en_d;
      RF_RD_EN    <= rd_en_d;
      RF_ADDR     <= addr_d;
      RF_WR_DATA  <= wdata_d;
      ALU_EN      <= alu_en_d;
      ALU_FUN     <= fun_d;
      CLK_GATE_EN <= gate_d;
      CMD_ERR     <= err_evt;
    end
  end

  // Frame capture, response buffer and timeout counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd       <= CMD_WR;
      addr      <= '0;
      cnt       <= '0;
      alu_start <= 1'b0;
      tx_buf    <= '0;
      tx_left   <= '0;
      err_q     <= '0;
      tmo_cnt   <= '0;
    end else begin
      err_q     <= err_q_nxt;
      alu_start <= (state == GET_FUN) && RX_D_VLD;
      if (!timed || state_nxt != state || RX_D_VLD) tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (state == IDLE && RX_D_VLD) begin
        case (RX_D[7:0])
          8'hBB:   cmd <= CMD_RD;
          8'hEE:   cmd <= CMD_BURST;
          default: cmd <= CMD_WR;
        endcase
      end
      if (state == GET_ADDR && RX_D_VLD)        addr <= RX_D[ADDR_WIDTH-1:0];
      else if (state == BURST_DATA && RX_D_VLD) addr <= addr + ADDR_WIDTH'(1);
      if (state == GET_CNT && RX_D_VLD)         cnt <= RX_D;
      else if (state == BURST_DATA && RX_D_VLD) cnt <= cnt - BUS_WIDTH'(1);
      if (rd_cap) begin
        tx_buf  <= OUT_W'(RF_RD_DATA);
        tx_left <= TXL_W'(1);
      end else if (alu_cap) begin
        tx_buf  <= ALU_OUT;
        tx_left <= TXL_W'(ALU_OUT_BYTES);
      end else if (tx_wr && tx_left != '0) begin
        tx_buf  <= tx_buf >> BUS_WIDTH;
        tx_left <= tx_left - TXL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
module tb_sys_ctrl_gen2;
  localparam int BW = 8, AW = 4, FW = 4, OB = 2, TMO = 16;
`ifdef SYS_CTRL_ERR_RESP_EN
  localparam int ERR_TOK = 1;
`else
  localparam int ERR_TOK = 0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [BW-1:0]    RX_D = '0;
  logic             RX_D_VLD = 1'b0;
  logic [BW-1:0]    RF_RD_DATA = '0;
  logic             RF_RD_VLD = 1'b0;
  logic [OB*BW-1:0] ALU_OUT = '0;
  logic             ALU_OUT_VLD = 1'b0;
  logic             FIFO_FULL = 1'b0;
  logic             RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, FIFO_WR_INC, CMD_ERR, BUSY;
  logic [AW-1:0]    RF_ADDR;
  logic [BW-1:0]    RF_WR_DATA, FIFO_WR_DATA;
  logic [FW-1:0]    ALU_FUN;

  sys_ctrl_gen2 #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .ALU_FUN_W(FW),
                  .ALU_OUT_BYTES(OB), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .RX_D(RX_D), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR),
    .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_GATE_EN(CLK_GATE_EN), .FIFO_WR_DATA(FIFO_WR_DATA),
    .FIFO_WR_INC(FIFO_WR_INC), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Event recorder, sampled on the falling edge
  logic [AW+BW-1:0] wrq[$];
  logic [BW-1:0]    fifoq[$];
  int rd_cnt = 0, alu_cnt = 0, err_cnt = 0, full_viol = 0, excl_viol = 0;

  always @(negedge CLK) begin
    if (RF_WR_EN) wrq.push_back({RF_ADDR, RF_WR_DATA});
    if (RF_RD_EN) rd_cnt++;
    if (RF_WR_EN && RF_RD_EN) excl_viol++;
    if (ALU_EN) alu_cnt++;
    if (CMD_ERR) err_cnt++;
    if (FIFO_WR_INC) begin
      if (FIFO_FULL) full_viol++;
      else fifoq.push_back(FIFO_WR_DATA);
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] b);
    RX_D = b;
    RX_D_VLD = 1'b1;
    tick(1);
    RX_D_VLD = 1'b0;
    RX_D = '0;
  endtask

  task automatic clr();
    wrq.delete();
    fifoq.delete();
    rd_cnt = 0; alu_cnt = 0; err_cnt = 0;
  endtask

  function automatic logic [31:0] wr_at(input int i);
    return (wrq.size() > i) ? 32'(wrq[i]) : 32'hFFFF;
  endfunction

  function automatic logic [31:0] fifo_at(input int i);
    return (fifoq.size() > i) ? 32'(fifoq[i]) : 32'h0;
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN,
                CLK_GATE_EN, FIFO_WR_DATA, FIFO_WR_INC, CMD_ERR, BUSY});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk("reset_outputs", all_out(), 0);
    RST = 1'b1;
    tick(1);

    // RF write
    clr();
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_en", 32'(RF_WR_EN), 1);
    chk("wr_addr", 32'(RF_ADDR), 5);
    chk("wr_data", 32'(RF_WR_DATA), 32'h3C);
    tick(1);
    chk("wr_once", wrq.size(), 1);
    chk("busy_after_wr", 32'(BUSY), 0);

    // RF read with FIFO stall
    clr();
    send(8'hBB); send(8'h02);
    chk("rd_en", 32'(RF_RD_EN), 1);
    chk("rd_addr", 32'(RF_ADDR), 2);
    FIFO_FULL = 1'b1;
    tick(1);
    RF_RD_DATA = 8'h81; RF_RD_VLD = 1'b1;
    tick(1);
    RF_RD_VLD = 1'b0;
    tick(8);
    chk("rd_stall_nopush", fifoq.size(), 0);
    chk("rd_stall_busy", 32'(BUSY), 1);
    FIFO_FULL = 1'b0;
    tick(3);
    chk("rd_push_cnt", fifoq.size(), 1);
    chk("rd_push_data", fifo_at(0), 32'h81);
    chk("rd_en_once", rd_cnt, 1);
    chk("rd_busy_end", 32'(BUSY), 0);

    // Operand ALU command
    clr();
    send(8'hCC); send(8'h0A); send(8'h03); send(8'h00);
    chk("alu_gate_on", 32'(CLK_GATE_EN), 1);
    chk("alu_en_not_yet", 32'(ALU_EN), 0);
    tick(1);
    chk("alu_en_pulse", 32'(ALU_EN), 1);
    tick(3);
    chk("alu_gate_hold", 32'(CLK_GATE_EN), 1);
    ALU_OUT = 16'h000D; ALU_OUT_VLD = 1'b1;
    tick(1);
    ALU_OUT_VLD = 1'b0;
    chk("alu_gate_drop", 32'(CLK_GATE_EN), 0);
    tick(4);
    chk("alu_fifo_cnt", fifoq.size(), 2);
    chk("alu_fifo_b0", fifo_at(0), 32'h0D);
    chk("alu_fifo_b1", fifo_at(1), 32'h00);
    chk("alu_wr_a", wr_at(0), 32'h00A);
    chk("alu_wr_b", wr_at(1), 32'h103);
    chk("alu_en_once", alu_cnt, 1);
    chk("alu_busy_end", 32'(BUSY), 0);

    // Burst write with address wrap, then zero count
    clr();
    send(8'hEE); send(8'h0E); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    tick(2);
    chk("burst_cnt", wrq.size(), 3);
    chk("burst_w0", wr_at(0), 32'hE11);
    chk("burst_w1", wr_at(1), 32'hF22);
    chk("burst_w2_wrap", wr_at(2), 32'h033);
    clr();
    send(8'hEE); send(8'h04); send(8'h00);
    tick(3);
    chk("burst0_err", err_cnt, 1);
    chk("burst0_nowr", wrq.size(), 0);
    chk("burst0_fifo", fifoq.size(), ERR_TOK);
    chk("burst0_idle", 32'(BUSY), 0);

    // Inter-byte timeout, then a normal frame
    clr();
    send(8'hAA); send(8'h01);
    tick(TMO - 1);
    chk("tmo_not_yet", err_cnt, 0);
    chk("tmo_busy", 32'(BUSY), 1);
    tick(2);
    chk("tmo_err", err_cnt, 1);
    chk("tmo_idle", 32'(BUSY), 0);
    clr();
    send(8'hAA); send(8'h07); send(8'h5A);
    tick(1);
    chk("post_tmo_cnt", wrq.size(), 1);
    chk("post_tmo_wr", wr_at(0), 32'h75A);

    // Bad opcode
    clr();
    send(8'h55);
    tick(3);
    chk("badop_err", err_cnt, 1);
    chk("badop_fifo_cnt", fifoq.size(), ERR_TOK);
    chk("badop_fifo_data", fifo_at(0), (ERR_TOK != 0) ? 32'hFF : 32'h0);

    // Overrun during RD_WAIT: error pulse, read still completes
    clr();
    send(8'hBB); send(8'h03); send(8'h99);
    RF_RD_DATA = 8'h44; RF_RD_VLD = 1'b1;
    tick(1);
    RF_RD_VLD = 1'b0;
    tick(4);
    chk("ovr_err", err_cnt, 1);
    chk("ovr_fifo_cnt", fifoq.size(), 1 + ERR_TOK);
    chk("ovr_fifo_data", fifo_at(0), 32'h44);
    chk("ovr_idle", 32'(BUSY), 0);

    // No-operand ALU command that times out waiting for a result
    clr();
    send(8'hDD); send(8'h05);
    chk("dd_fun", 32'(ALU_FUN), 5);
    chk("dd_gate_on", 32'(CLK_GATE_EN), 1);
    tick(TMO + 3);
    chk("dd_tmo_gate", 32'(CLK_GATE_EN), 0);
    chk("dd_tmo_err", err_cnt, 1);
    chk("dd_alu_en", alu_cnt, 1);
    chk("dd_idle", 32'(BUSY), 0);

    // Reset in the middle of a burst
    clr();
    send(8'hEE); send(8'h00); send(8'h04); send(8'h11); send(8'h22);
    chk("rst_pre_wr", 32'(RF_WR_EN), 1);
    chk("rst_pre_addr", 32'(RF_ADDR), 1);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_async_out", all_out(), 0);
    @(negedge CLK);
    RST = 1'b1;
    tick(1);
    clr();
    send(8'h33); send(8'h44);
    tick(3);
    chk("rst_no_more_wr", wrq.size(), 0);

    chk("wr_rd_exclusive", excl_viol, 0);
    chk("no_push_when_full", full_viol, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/sys_ctrl_gen2.md
Name: sys_ctrl_gen2

Overview:
Second-generation system controller in the REF_CLK domain. Parses command frames arriving as synchronised UART RX bytes and drives the register file, the ALU and its clock gate. Pushes response bytes into the TX async FIFO. Generalises the first controller with parametrised data/address/result widths, a burst-write command, an inter-byte timeout and explicit error reporting.

Parameters:
BUS_WIDTH, 8, byte width of RX data, RF data and FIFO data
ADDR_WIDTH, 4, register file address width
ALU_FUN_W, 4, ALU function code width
ALU_OUT_BYTES, 2, ALU result width in bytes; result is sent LSB byte first
TIMEOUT_CYC, 1024, idle cycles tolerated mid-frame before abort (>=2)

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous, active-low reset
RX_D  in  BUS_WIDTH  synchronised RX byte
RX_D_VLD  in  1  one-cycle pulse, RX_D valid
RF_RD_DATA  in  BUS_WIDTH  register file read data
RF_RD_VLD  in  1  register file read data valid
ALU_OUT  in  ALU_OUT_BYTES*BUS_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid
FIFO_FULL  in  1  TX FIFO full
RF_WR_EN  out  1  register file write strobe
RF_RD_EN  out  1  register file read strobe
RF_ADDR  out  ADDR_WIDTH  register file address
RF_WR_DATA  out  BUS_WIDTH  register file write data
ALU_EN  out  1  ALU start pulse
ALU_FUN  out  ALU_FUN_W  ALU function
CLK_GATE_EN  out  1  ALU clock-gate enable
FIFO_WR_DATA  out  BUS_WIDTH  TX FIFO write data
FIFO_WR_INC  out  1  TX FIFO write strobe
CMD_ERR  out  1  one-cycle error pulse
BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset (RST=0, async): all outputs 0; state IDLE; internal counters and capture registers cleared.
- Opcodes, low 8 bits of the IDLE byte:
  - 0xAA addr data: RF write.
  - 0xBB addr: RF read.
  - 0xCC A B fun: operand ALU command.
  - 0xDD fun: no-operand ALU command.
  - 0xEE addr cnt d0..d(cnt-1): burst write.
- Any other opcode in IDLE -> CMD_ERR pulse, remain IDLE.
- States: IDLE, GET_ADDR, GET_WDATA, GET_CNT, BURST_DATA, RD_WAIT, GET_OPA, GET_OPB, GET_FUN, ALU_WAIT, TX_OUT.
- RF write:
  - The data byte produces a one-cycle RF_WR_EN with RF_ADDR and RF_WR_DATA valid in the same cycle, registered one cycle after the RX_D_VLD cycle.
  - Then IDLE.
- RF read:
  - The addr byte produces a one-cycle RF_RD_EN, then RD_WAIT.
  - On RF_RD_VLD, capture the data and go to TX_OUT with one byte to send.
- Operand ALU command (0xCC):
  - A is written to RF address 0 and B to RF address 1, each via one RF_WR_EN pulse.
  - The fun byte raises CLK_GATE_EN and latches ALU_FUN.
  - ALU_EN pulses one cycle later; state goes to ALU_WAIT.
  - 0xDD goes straight to this step.
- CLK_GATE_EN stays high from the fun byte until ALU_OUT_VLD is seen; it drops the cycle after capture.
- ALU_OUT is captured, then TX_OUT sends ALU_OUT_BYTES bytes.
- TX_OUT:
  - FIFO_WR_INC pulses for one cycle per byte, only in cycles where FIFO_FULL=0.
  - While FIFO_FULL=1, hold the byte and stall indefinitely; this stall does not count toward the timeout.
  - Return to IDLE after the last byte.
- Burst write:
  - cnt=0 -> CMD_ERR, IDLE.
  - Otherwise each data byte writes RF_ADDR, then increments the address modulo 2^ADDR_WIDTH (wrap 15->0 at default).
  - Return to IDLE after cnt writes.
- Timeout:
  - In any GET_*/BURST_DATA/RD_WAIT/ALU_WAIT state, a counter reloads on each RX_D_VLD or state change.
  - On reaching TIMEOUT_CYC: CMD_ERR pulse; CLK_GATE_EN, ALU_EN and RF strobes deasserted; state IDLE.
- Overrun: RX_D_VLD in RD_WAIT, ALU_WAIT or TX_OUT -> byte dropped, CMD_ERR pulse, current command continues.
- Simultaneous events:
  - RX_D_VLD in the same cycle as the timeout expiry: the byte wins and the counter reloads.
  - ALU_OUT_VLD and the timeout in the same cycle: the result wins.
- At most one of RF_WR_EN and RF_RD_EN is high in any cycle.

Optional Feature:
SYS_CTRL_ERR_RESP_EN
- Defined: every CMD_ERR event also queues an all-ones BUS_WIDTH error token into the TX FIFO through TX_OUT, with normal FIFO_FULL stalling.
- On an overrun error, the token is sent after the in-progress response bytes.
- Undefined: CMD_ERR pulse only; no FIFO traffic on errors.

Test Plan:
- RX 0xAA,0x05,0x3C -> single RF_WR_EN, RF_ADDR=5, RF_WR_DATA=0x3C; BUSY low afterwards.
- RX 0xBB,0x02; RF returns 0x81 two cycles later; FIFO_FULL held 1 for 10 cycles -> no FIFO_WR_INC while full, then exactly one FIFO_WR_INC with 0x81.
- RX 0xCC,0x0A,0x03,0x00; ALU returns 0x000D -> writes to addr0=0x0A and addr1=0x03, ALU_EN once, CLK_GATE_EN high until capture, FIFO bytes 0x0D then 0x00.
- RX 0xEE,0x0E,0x03,0x11,0x22,0x33 -> writes addr 14=0x11, 15=0x22, 0=0x33 (wrap-around); 0xEE,0x04,0x00 -> CMD_ERR, no writes.
- RX 0xAA,0x01 then silence for TIMEOUT_CYC cycles -> one CMD_ERR, IDLE; next 0xAA frame executes normally. Opcode 0x55 -> CMD_ERR.
- Assert RST mid-burst after 2 of 4 bytes -> all outputs 0 immediately; no further writes after release. With SYS_CTRL_ERR_RESP_EN, the opcode-0x55 case pushes 0xFF to the FIFO.
